piece_spawner: RTL and testbench

PIECE_SPAWNER -- requirements
Module: piece_spawner

---
 rtl/piece_spawner.sv | 135 +++++++++++++
 tb/tb_piece_spawner.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/piece_spawner.sv
// rtl/piece_spawner.sv - tetromino spawner: LFSR-driven piece draw with one anti-repeat reroll
`timescale 1ns/1ps
module piece_spawner #(
    parameter logic [3:0]  SPAWN_X   = 4'd3,
    parameter logic [4:0]  SPAWN_Y   = 5'd0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spawn_req,
    output logic [3:0]  x,
    output logic [4:0]  y,
    output logic [0:15] float,
    output logic [2:0]  kind,
    output logic [2:0]  next_kind,
    output logic        spawn_valid,
    output logic        busy
);

    // An all-zero LFSR would lock up, so a zero seed is replaced.
    localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_DRAW, S_EMIT} state_t;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [2:0]  kind_q, kind_d;
    logic [2:0]  next_kind_q, next_kind_d;
    logic        reroll_q, reroll_d;
    logic [3:0]  x_q, x_d;
    logic [4:0]  y_q, y_d;
    logic [0:15] float_q, float_d;
    logic        valid_q, valid_d;
    logic [2:0]  cand;

    function automatic logic [0:15] shape(input logic [2:0] k);
        case (k)
            3'd0:    shape = 16'b0000111100000000;
            3'd1:    shape = 16'b0110011000000000;
            3'd2:    shape = 16'b0100111000000000;
            3'd3:    shape = 16'b0110110000000000;
            3'd4:    shape = 16'b1100011000000000;
            3'd5:    shape = 16'b1000111000000000;
            3'd6:    shape = 16'b0010111000000000;
            default: shape = 16'b0000000000000000;
        endcase
    endfunction

    assign cand   = lfsr_q[2:0];
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            lfsr_q      <= SEED_EFF;
            kind_q      <= 3'd0;
            next_kind_q <= 3'd0;
            reroll_q    <= 1'b0;
            x_q         <= SPAWN_X;
            y_q         <= SPAWN_Y;
            float_q     <= 16'h0000;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            kind_q      <= kind_d;
            next_kind_q <= next_kind_d;
            reroll_q    <= reroll_d;
            x_q         <= x_d;
            y_q         <= y_d;
            float_q     <= float_d;
            valid_q     <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT: if (cand != 3'd7) state_d = S_IDLE;
            S_IDLE: if (spawn_req) state_d = S_DRAW;
            S_DRAW: begin
                if (cand != 3'd7 && !(cand == kind_q && !reroll_q)) begin
                    state_d = S_EMIT;
                end
            end
            S_EMIT: state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase
    end

    always_comb begin
        kind_d      = kind_q;
        next_kind_d = next_kind_q;
        reroll_d    = reroll_q;
        x_d         = x_q;
        y_d         = y_q;
        float_d     = float_q;
        valid_d     = 1'b0;
        case (state_q)
            S_INIT: if (cand != 3'd7) next_kind_d = cand;
            S_IDLE: begin
                if (spawn_req) begin
                    kind_d   = next_kind_q;
                    reroll_d = 1'b0;
                end
            end
            S_DRAW: begin
                // A repeat of the current piece is rejected once; a second repeat is kept.
                if (cand == 3'd7) begin
                    next_kind_d = next_kind_q;
                end else if (cand == kind_q && !reroll_q) begin
                    reroll_d = 1'b1;
                end else begin
                    next_kind_d = cand;
                end
            end
            S_EMIT: begin
                x_d     = SPAWN_X;
                y_d     = SPAWN_Y;
                float_d = shape(kind_q);
                valid_d = 1'b1;
            end
            default: valid_d = 1'b0;
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign x           = x_q;
    assign y           = y_q;
    assign float       = float_q;
    assign kind        = kind_q;
    assign next_kind   = next_kind_q;
    assign spawn_valid = valid_q;

endmodule

// File: tb/tb_piece_spawner.sv
// tb/tb_piece_spawner.sv - randomized scoreboard bench for piece_spawner
`timescale 1ns/1ps
module tb_piece_spawner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spawn_req;
    logic [3:0]  x;
    logic [4:0]  y;
    logic [0:15] flt;
    logic [2:0]  kind;
    logic [2:0]  next_kind;
    logic        spawn_valid;
    logic        busy;

    always #5 clk = ~clk;

    piece_spawner dut (
        .clk(clk), .rst_n(rst_n), .spawn_req(spawn_req),
        .x(x), .y(y), .float(flt), .kind(kind), .next_kind(next_kind),
        .spawn_valid(spawn_valid), .busy(busy)
    );

    typedef struct {
        int         due;
        logic [2:0] kind;
        logic [2:0] nk;
    } exp_t;

    exp_t        sbq[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          free_at  = -1;
    int          nk_at    = -1;
    logic [2:0]  nk_val   = 3'd0;
    logic [2:0]  m_kind   = 3'd0;
    logic [2:0]  exp_next = 3'd0;
    logic [15:0] m_lfsr   = 16'hACE1;
    bit          init_pending = 1'b0;
    bit          mon_on   = 1'b0;
    logic        busy_exp = 1'b1;
    logic [3:0]  held_x   = 4'd3;
    logic [4:0]  held_y   = 5'd0;
    logic [0:15] held_f   = 16'h0000;
    int          spawns   = 0;
    int          skip7    = 0;
    int          rerolls  = 0;
    int          rep2     = 0;
    logic [6:0]  seen     = 7'd0;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [0:15] shape_of(input logic [2:0] k);
        logic [0:15] s;
        case (k)
            3'd0: s = 16'b0000111100000000;
            3'd1: s = 16'b0110011000000000;
            3'd2: s = 16'b0100111000000000;
            3'd3: s = 16'b0110110000000000;
            3'd4: s = 16'b1100011000000000;
            3'd5: s = 16'b1000111000000000;
            3'd6: s = 16'b0010111000000000;
            default: s = 16'hFFFF;
        endcase
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a spawn is resolved as a whole by scanning the LFSR sequence.
    always @(posedge clk) begin
        logic [15:0] v;
        int          j;
        bit          rr;
        logic [2:0]  c;
        cyc++;
        if (!rst_n) begin
            mon_on       = 1'b1;
            init_pending = 1'b1;
            m_lfsr       = 16'hACE1;
            m_kind       = 3'd0;
            exp_next     = 3'd0;
            free_at      = -1;
            nk_at        = -1;
            sbq.delete();
            held_x       = 4'd3;
            held_y       = 5'd0;
            held_f       = 16'h0000;
            busy_exp     = 1'b1;
        end else begin
            if (init_pending) begin
                v = m_lfsr;
                j = 0;
                while (v[2:0] == 3'd7) begin
                    v = lfsr_step(v);
                    j++;
                end
                nk_at        = cyc + j;
                nk_val       = v[2:0];
                free_at      = cyc + j + 1;
                init_pending = 1'b0;
            end else if (cyc == free_at) begin
                if (spawn_req) begin
                    m_kind = exp_next;
                    v  = lfsr_step(m_lfsr);
                    j  = 0;
                    rr = 1'b0;
                    while (1) begin
                        c = v[2:0];
                        if (c == 3'd7) skip7++;
                        else if (c == m_kind && !rr) begin
                            rr = 1'b1;
                            rerolls++;
                        end else break;
                        v = lfsr_step(v);
                        j++;
                    end
                    if (rr && c == m_kind) rep2++;
                    nk_at   = cyc + 1 + j;
                    nk_val  = c;
                    sbq.push_back('{cyc + 2 + j, m_kind, c});
                    free_at = cyc + 3 + j;
                end else begin
                    free_at = cyc + 1;
                end
            end
            if (cyc == nk_at) exp_next = nk_val;
            m_lfsr   = lfsr_step(m_lfsr);
            busy_exp = !(free_at == cyc + 1 && !init_pending);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (mon_on) begin
            if (spawn_valid) begin
                if (sbq.size() == 0) begin
                    chk("spawn_valid_unexpected", spawn_valid, 1'b0);
                end else begin
                    e = sbq[0];
                    sbq.delete(0);
                    chk("spawn_cycle", cyc, e.due);
                    chk("spawn_kind", kind, e.kind);
                    chk("spawn_next_kind", next_kind, e.nk);
                    chk("spawn_float", flt, shape_of(e.kind));
                    held_x = 4'd3;
                    held_y = 5'd0;
                    held_f = shape_of(e.kind);
                    spawns++;
                    seen[e.kind] = 1'b1;
                end
            end else if (sbq.size() > 0 && sbq[0].due < cyc) begin
                chk("spawn_valid_missing", spawn_valid, 1'b1);
                sbq.delete(0);
            end
            chk("busy", busy, busy_exp);
            chk("kind", kind, m_kind);
            chk("next_kind", next_kind, exp_next);
            chk("x", x, held_x);
            chk("y", y, held_y);
            chk("float", flt, held_f);
        end
    end

    initial begin
        rst_n     = 1'b0;
        spawn_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 1'b1);
        chk("reset_float", flt, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("init_next_kind_O", next_kind, 3'd1);
        chk("init_idle", busy, 1'b0);

        spawn_req = 1'b1;
        @(negedge clk);
        spawn_req = 1'b0;
        chk("first_kind_O", kind, 3'd1);
        for (int i = 0; i < 20 && !spawn_valid; i++) @(negedge clk);
        chk("first_spawn_seen", spawn_valid, 1'b1);
        chk("first_spawn_x", x, 4'd3);
        chk("first_spawn_y", y, 5'd0);
        chk("first_spawn_float", flt, 16'b0110011000000000);

        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        spawn_req = 1'b1;
        @(negedge clk);
        spawn_req = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", busy, 1'b1);
        chk("abort_no_valid", spawn_valid, 1'b0);
        chk("abort_kind", kind, 3'd0);

        while (spawns < 10000 && cyc < 90000) begin
            @(negedge clk);
            spawn_req = ($urandom_range(0, 15) != 0);
        end
        spawn_req = 1'b0;
        repeat (10) @(negedge clk);
        chk("spawn_total_reached", (spawns >= 10000), 1'b1);
        chk("scoreboard_drained", sbq.size(), 0);
        chk("all_kinds_seen", seen, 7'h7F);
        chk("draw_skipped_7", (skip7 > 0), 1'b1);
        chk("draw_rerolled", (rerolls > 0), 1'b1);
        chk("second_repeat_kept", (rep2 > 0), 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
